// File: rtl/axi_rd_arbiter.sv
// -----------------------------------------------------------------------------
// axi_rd_arbiter
//   Two-master to one-slave AXI read-channel arbiter. Only one read is in
//   flight at a time. The slave sees at most one outstanding transaction.
//   Simultaneous requests are resolved round-robin against the master that
//   completed the previous read.
//
// Ports
//   clk, rst          : clock and asynchronous active-low reset (0 = reset)
//   m0_* (IFU)        : master 0 AR channel (araddr/arvalid/arready) and
//                       R channel (rdata/rresp/rvalid/rready)
//   m1_* (LSU)        : master 1, same shape as master 0
//   s_*               : slave (memory) AR and R channels
//   busy              : high whenever the FSM is not idle
//   grant_id          : master owning the current or most recent transaction
// -----------------------------------------------------------------------------
module axi_rd_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,

  input  logic [ADDR_W-1:0] m0_araddr,
  input  logic              m0_arvalid,
  output logic              m0_arready,
  output logic [DATA_W-1:0] m0_rdata,
  output logic [1:0]        m0_rresp,
  output logic              m0_rvalid,
  input  logic              m0_rready,

  input  logic [ADDR_W-1:0] m1_araddr,
  input  logic              m1_arvalid,
  output logic              m1_arready,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [1:0]        m1_rresp,
  output logic              m1_rvalid,
  input  logic              m1_rready,

  output logic [ADDR_W-1:0] s_araddr,
  output logic              s_arvalid,
  input  logic              s_arready,
  input  logic [DATA_W-1:0] s_rdata,
  input  logic [1:0]        s_rresp,
  input  logic              s_rvalid,
  output logic              s_rready,

  output logic              busy,
  output logic              grant_id
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_ADDR = 2'b01,
    ST_DATA = 2'b10
  } state_t;

  state_t            state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic              grant_id_q, grant_id_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  logic              req_any;
  logic              win_id;
  logic              in_idle;
  logic              in_addr;
  logic              in_data;
  logic              fwd_rready;

  assign in_idle = (state_q == ST_IDLE);
  assign in_addr = (state_q == ST_ADDR);
  assign in_data = (state_q == ST_DATA);

  // Round-robin: on a tie the master that did not finish last wins;
  // otherwise the single requester wins.
  assign req_any = m0_arvalid | m1_arvalid;
  assign win_id  = (m0_arvalid && m1_arvalid) ? ~last_grant_q : m1_arvalid;

  // R-channel ready comes straight from the owning master.
  assign fwd_rready = grant_id_q ? m1_rready : m0_rready;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_id_d   = grant_id_q;
    addr_d       = addr_q;
    case (state_q)
      ST_IDLE: begin
        if (req_any) begin
          addr_d     = win_id ? m1_araddr : m0_araddr;
          grant_id_d = win_id;
          state_d    = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (s_arready) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (s_rvalid && fwd_rready) begin
          last_grant_d = grant_id_q;
          state_d      = ST_IDLE;
        end
      end
      // Unreachable encodings recover to idle on the next edge.
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      grant_id_q   <= 1'b0;
      addr_q       <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_id_q   <= grant_id_d;
      addr_q       <= addr_d;
    end
  end

  // AR handshake with the winner is combinational in IDLE; it is masked
  // while reset is held because the idle state is also the reset state.
  assign m0_arready = rst && in_idle && req_any && !win_id;
  assign m1_arready = rst && in_idle && req_any &&  win_id;

  assign s_araddr  = addr_q;
  assign s_arvalid = in_addr;
  assign s_rready  = in_data && fwd_rready;

  assign m0_rvalid = in_data && !grant_id_q && s_rvalid;
  assign m1_rvalid = in_data &&  grant_id_q && s_rvalid;

  // Data and response are broadcast; rvalid alone qualifies them.
  assign m0_rdata = s_rdata;
  assign m1_rdata = s_rdata;
  assign m0_rresp = s_rresp;
  assign m1_rresp = s_rresp;

  assign busy     = !in_idle;
  assign grant_id = grant_id_q;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
module tb_axi_rd_arbiter;

  logic        clk;
  logic        rst;
  logic [31:0] m0_araddr, m1_araddr, s_araddr;
  logic        m0_arvalid, m0_arready, m1_arvalid, m1_arready;
  logic [31:0] m0_rdata, m1_rdata, s_rdata;
  logic [1:0]  m0_rresp, m1_rresp, s_rresp;
  logic        m0_rvalid, m0_rready, m1_rvalid, m1_rready;
  logic        s_arvalid, s_arready, s_rvalid, s_rready;
  logic        busy, grant_id;

  int checks = 0;
  int errors = 0;
  int hs_cnt = 0;

  axi_rd_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .m0_araddr(m0_araddr), .m0_arvalid(m0_arvalid), .m0_arready(m0_arready),
    .m0_rdata(m0_rdata), .m0_rresp(m0_rresp), .m0_rvalid(m0_rvalid), .m0_rready(m0_rready),
    .m1_araddr(m1_araddr), .m1_arvalid(m1_arvalid), .m1_arready(m1_arready),
    .m1_rdata(m1_rdata), .m1_rresp(m1_rresp), .m1_rvalid(m1_rvalid), .m1_rready(m1_rready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .busy(busy), .grant_id(grant_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (s_rvalid && s_rready) hs_cnt <= hs_cnt + 1;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic set_rready(input logic gid, input logic v);
    if (gid) m1_rready = v;
    else     m0_rready = v;
  endtask

  // Entered at a negedge with the FSM idle and the winner's request driven.
  task automatic txn(input logic exp_gid, input logic [31:0] exp_addr,
                     input logic [31:0] rd, input logic [1:0] rr,
                     input int ar_wait, input int r_wait, input bit drop);
    #1;
    chk("busy_idle",   64'(busy), 64'(0));
    chk("arvalid_idl", 64'(s_arvalid), 64'(0));
    chk("arready0",    64'(m0_arready), 64'(exp_gid == 1'b0));
    chk("arready1",    64'(m1_arready), 64'(exp_gid == 1'b1));
    @(posedge clk); @(negedge clk);
    if (drop) begin
      if (exp_gid) m1_arvalid = 1'b0;
      else         m0_arvalid = 1'b0;
    end
    s_arready = 1'b0;
    #1;
    chk("grant_id",  64'(grant_id), 64'(exp_gid));
    chk("busy_addr", 64'(busy), 64'(1));
    chk("arrdy_out", 64'({m0_arready, m1_arready}), 64'(0));
    for (int i = 0; i < ar_wait; i++) begin
      chk("ar_wait_v", 64'(s_arvalid), 64'(1));
      chk("ar_wait_a", 64'(s_araddr), 64'(exp_addr));
      chk("rrdy_addr", 64'(s_rready), 64'(0));
      @(posedge clk); @(negedge clk); #1;
    end
    s_arready = 1'b1;
    #1;
    chk("s_arvalid", 64'(s_arvalid), 64'(1));
    chk("s_araddr",  64'(s_araddr), 64'(exp_addr));
    @(posedge clk); @(negedge clk);
    s_arready = 1'b0;
    s_rvalid  = 1'b1;
    s_rdata   = rd;
    s_rresp   = rr;
    set_rready(exp_gid, (r_wait == 0));
    for (int i = 0; i < r_wait; i++) begin
      #1;
      chk("rw_arvalid", 64'(s_arvalid), 64'(0));
      chk("rw_rready",  64'(s_rready), 64'(0));
      chk("rw_rvalid",  64'({m1_rvalid, m0_rvalid}), exp_gid ? 64'(2) : 64'(1));
      @(posedge clk); @(negedge clk);
    end
    set_rready(exp_gid, 1'b1);
    #1;
    chk("d_arvalid", 64'(s_arvalid), 64'(0));
    chk("d_rready",  64'(s_rready), 64'(1));
    chk("d_rvalid",  64'({m1_rvalid, m0_rvalid}), exp_gid ? 64'(2) : 64'(1));
    chk("d_rdata",   exp_gid ? 64'(m1_rdata) : 64'(m0_rdata), 64'(rd));
    chk("d_rresp",   exp_gid ? 64'(m1_rresp) : 64'(m0_rresp), 64'(rr));
    chk("d_arrdy",   64'({m0_arready, m1_arready}), 64'(0));
    @(posedge clk); @(negedge clk);
    s_rvalid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    @(posedge clk); @(negedge clk);
    rst = 1'b1;
  endtask

  int hs_before;

  initial begin
    rst = 1'b0;
    m0_araddr = 32'h0; m1_araddr = 32'h0;
    m0_arvalid = 1'b1; m1_arvalid = 1'b1;
    m0_rready = 1'b1;  m1_rready = 1'b1;
    s_arready = 1'b0;  s_rvalid = 1'b0;
    s_rdata = 32'h0;   s_rresp = 2'b00;

    // Reset values, with requests present to show arready is masked.
    #3;
    chk("rst_arrdy",  64'({m0_arready, m1_arready}), 64'(0));
    chk("rst_busy",   64'(busy), 64'(0));
    chk("rst_gid",    64'(grant_id), 64'(0));
    chk("rst_araddr", 64'(s_araddr), 64'(0));
    chk("rst_sv",     64'({s_arvalid, s_rready, m0_rvalid, m1_rvalid}), 64'(0));
    @(negedge clk);
    m0_arvalid = 1'b0; m1_arvalid = 1'b0;
    @(posedge clk); @(negedge clk);
    rst = 1'b1;
    @(posedge clk); @(negedge clk);

    // Single m0 read.
    m0_araddr = 32'h8000_0000; m0_arvalid = 1'b1;
    txn(1'b0, 32'h8000_0000, 32'h0000_0413, 2'b00, 0, 0, 1'b1);
    #1 chk("t1_busy", 64'(busy), 64'(0));
    chk("t1_hs", 64'(hs_cnt), 64'(1));
    @(negedge clk);

    // Simultaneous first requests after reset: m0 then m1.
    do_reset();
    m0_araddr = 32'h8000_0010; m1_araddr = 32'h8000_1000;
    m0_arvalid = 1'b1; m1_arvalid = 1'b1;
    txn(1'b0, 32'h8000_0010, 32'h1111_1111, 2'b00, 0, 0, 1'b1);
    txn(1'b1, 32'h8000_1000, 32'h2222_2222, 2'b00, 0, 0, 1'b1);

    // Continuous contention: last grant was 1, so 0,1,0,1.
    m0_araddr = 32'h0000_0100; m1_araddr = 32'h0000_0200;
    m0_arvalid = 1'b1; m1_arvalid = 1'b1;
    txn(1'b0, 32'h0000_0100, 32'hA0A0_0001, 2'b00, 0, 0, 1'b0);
    txn(1'b1, 32'h0000_0200, 32'hA0A0_0002, 2'b00, 0, 0, 1'b0);
    txn(1'b0, 32'h0000_0100, 32'hA0A0_0003, 2'b00, 0, 0, 1'b0);
    m0_arvalid = 1'b0;
    txn(1'b1, 32'h0000_0200, 32'hA0A0_0004, 2'b00, 0, 0, 1'b1);

    // Backpressure on both slave AR and master R.
    hs_before = hs_cnt;
    m1_araddr = 32'h0000_BEE0; m1_arvalid = 1'b1;
    txn(1'b1, 32'h0000_BEE0, 32'hCAFE_F00D, 2'b00, 3, 2, 1'b1);
    chk("bp_one_hs", 64'(hs_cnt - hs_before), 64'(1));

    // Error response passthrough on m1.
    m1_araddr = 32'h0000_0E00; m1_arvalid = 1'b1;
    txn(1'b1, 32'h0000_0E00, 32'hDEAD_0000, 2'b10, 0, 0, 1'b1);
    #1 chk("err_idle", 64'(busy), 64'(0));
    @(negedge clk);

    // m0 completes so the next tie would favour m1 unless reset restores.
    m0_araddr = 32'h0000_0040; m0_arvalid = 1'b1;
    txn(1'b0, 32'h0000_0040, 32'h0000_0040, 2'b00, 0, 0, 1'b1);

    // Reset mid-transaction while the slave presents data.
    hs_before = hs_cnt;
    m1_araddr = 32'h0000_0080; m1_arvalid = 1'b1;
    @(posedge clk); @(negedge clk);
    m1_arvalid = 1'b0; s_arready = 1'b1;
    @(posedge clk); @(negedge clk);
    s_arready = 1'b0; s_rvalid = 1'b1; s_rdata = 32'h5555_AAAA;
    #1 chk("mid_rvalid", 64'(m1_rvalid), 64'(1));
    rst = 1'b0;
    #1;
    chk("mid_outs", 64'({s_arvalid, s_rready, m0_rvalid, m1_rvalid, m0_arready, m1_arready}), 64'(0));
    chk("mid_busy", 64'(busy), 64'(0));
    chk("mid_gid",  64'(grant_id), 64'(0));
    @(posedge clk); @(negedge clk);
    s_rvalid = 1'b0;
    rst = 1'b1;
    chk("mid_no_hs", 64'(hs_cnt - hs_before), 64'(0));
    m0_araddr = 32'h0000_1230; m1_araddr = 32'h0000_4560;
    m0_arvalid = 1'b1; m1_arvalid = 1'b1;
    txn(1'b0, 32'h0000_1230, 32'h0000_0001, 2'b00, 0, 0, 1'b1);
    txn(1'b1, 32'h0000_4560, 32'h0000_0002, 2'b00, 0, 0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_rd_arbiter.md
AXI_RD_ARBITER -- requirements
Module: axi_rd_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning address width of all AR channels.
REQ-002 SHALL have parameter DATA_W, default 32, meaning data width of all R channels.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset; 0 = reset asserted.
REQ-005 SHALL have ports m0_araddr input ADDR_W, m0_arvalid input 1, m0_arready output 1  for the master 0 (IFU) read-address channel.
REQ-006 SHALL have ports m0_rdata output DATA_W, m0_rresp output 2, m0_rvalid output 1, m0_rready input 1  for the master 0 read-data channel.
REQ-007 SHALL have ports m1_araddr, m1_arvalid, m1_arready, m1_rdata, m1_rresp, m1_rvalid, m1_rready  with the same directions and widths as master 0, for master 1 (LSU).
REQ-008 SHALL have ports s_araddr output ADDR_W, s_arvalid output 1, s_arready input 1  for the slave (memory) read-address channel.
REQ-009 SHALL have ports s_rdata input DATA_W, s_rresp input 2, s_rvalid input 1, s_rready output 1  for the slave read-data channel.
REQ-010 SHALL have port busy  output 1  high whenever the state is not IDLE.
REQ-011 SHALL have port grant_id  output 1  index of the master owning the current or last transaction.

Function
REQ-012 SHALL implement a three-state FSM: IDLE, ADDR (slave address phase), DATA (slave data phase).
REQ-013 IDLE: when only one of m0_arvalid/m1_arvalid is high, that master wins; when both are high, the master other than last_grant wins (round-robin).
REQ-014 IDLE: assert mX_arready combinationally to the winner only; in the same cycle, latch mX_araddr into the address register, set grant_id to X, and move to ADDR.
REQ-015 Outside IDLE, SHALL hold m0_arready = m1_arready = 0; new requests wait and are never lost or merged.
REQ-016 ADDR: s_arvalid = 1 with s_araddr = latched address, held stable until s_arready; on s_arvalid && s_arready go to DATA.
REQ-017 s_arvalid SHALL be 0 in IDLE and DATA; the first s_arvalid occurs exactly one cycle after the master AR handshake.
REQ-018 DATA: s_rready = m<grant_id>_rready; m<grant_id>_rvalid = s_rvalid; the non-granted master's rvalid = 0.
REQ-019 m0_rdata/m1_rdata and m0_rresp/m1_rresp SHALL carry s_rdata/s_rresp unmodified; validity is given only by the corresponding rvalid.
REQ-020 DATA: on s_rvalid && s_rready, update last_grant := grant_id and return to IDLE; arbitration may grant again in the very next cycle (one IDLE cycle between transactions).
REQ-021 s_rready SHALL be 0 in IDLE and ADDR.
REQ-022 At most one transaction SHALL be outstanding on the slave at any time.
REQ-023 An unknown state encoding SHALL transition to IDLE on the next clock edge.
REQ-024 s_rresp SHALL be passed through unchanged, including error codes; the arbiter does not retry.

Reset
REQ-025 While rst = 0: state = IDLE, last_grant = 1 (so master 0 wins the first tie), grant_id = 0, address register = 0.
REQ-026 While rst = 0: s_arvalid = 0, s_rready = 0, m0_rvalid = m1_rvalid = 0, m0_arready = m1_arready = 0, busy = 0.
REQ-027 Reset asserted mid-transaction SHALL abandon the transaction immediately, with no completion delivered to any master.

Verification
REQ-028 Single m0 read: m0_araddr=0x80000000, arvalid for 1 cycle; slave arready=1, rvalid one cycle later with rdata=0x00000413 -> m0_rvalid=1, m0_rdata=0x00000413, m1_rvalid=0, busy falls after the R handshake.
REQ-029 Simultaneous first requests: m0=0x80000010, m1=0x80001000 -> m0 served first; m1 is granted in the IDLE cycle after m0's R handshake; s_araddr sequence is 0x80000010, then 0x80001000.
REQ-030 Continuous contention, both arvalid held high for 4 transactions -> grants alternate 0,1,0,1; s_arvalid is never high during DATA.
REQ-031 Backpressure: s_arready low for 3 cycles, m1_rready low for 2 cycles after s_rvalid -> s_araddr stable throughout, s_rready tracks m1_rready, and exactly one R handshake occurs.
REQ-032 Reset mid-op: rst=0 during DATA with s_rvalid=1 -> outputs reach their REQ-026 values immediately; after release, the first tie goes to m0.
REQ-033 Error passthrough: s_rresp=2'b10 on m1 read -> m1_rresp=2'b10, m1_rvalid=1, and the FSM returns to IDLE normally.
